// File: rtl/mcpu_ctrl_fsm.sv
// Purpose: multi-cycle MIPS control FSM driving the shared PC/IR/MDR/A/B/ALUOut datapath.
// Latency: 3 cycles (j/jal/jr/beq/bne/lui), 4 (R-type/I-ALU/sw), 5 (lw) with memory always ready.
// Backpressure: MIO_ready=0 holds the FSM in IF/MRD/MWR; each stalled cycle adds one cycle.
//
// Ports:
//   clk, rst                 rising-edge clock, asynchronous active-high reset
//   OPcode, Fun              latched IR[31:26] / IR[5:0]
//   zero, MIO_ready          ALU zero flag, memory/IO access complete this cycle
//   PCWrite..ALU_Control     per-cycle datapath enables and mux selects
//   illegal                  one-cycle pulse in ID on an unsupported instruction
//   state_out                current state number for debug display
module mcpu_ctrl_fsm #(
  parameter logic [2:0] ALU_ADD = 3'b010,
  parameter int         ST_W    = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [5:0]      OPcode,
  input  logic [5:0]      Fun,
  input  logic            zero,
  input  logic            MIO_ready,
  output logic            PCWrite,
  output logic            IorD,
  output logic            MemRead,
  output logic            MemWrite,
  output logic            CPU_MIO,
  output logic            IRWrite,
  output logic [1:0]      RegDst,
  output logic [1:0]      MemtoReg,
  output logic            RegWrite,
  output logic            ALUSrcA,
  output logic [1:0]      ALUSrcB,
  output logic [1:0]      PCSource,
  output logic [2:0]      ALU_Control,
  output logic            illegal,
  output logic [ST_W-1:0] state_out
);

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_NOR = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [4:0] {
    S_IF    = 5'd0,  S_ID  = 5'd1,  S_EX_R = 5'd2,  S_WB_R = 5'd3,
    S_EX_I  = 5'd4,  S_WB_I = 5'd5, S_MA   = 5'd6,  S_MRD  = 5'd7,
    S_WB_LW = 5'd8,  S_MWR = 5'd9,  S_BEQ  = 5'd10, S_BNE  = 5'd11,
    S_JMP   = 5'd12, S_JAL = 5'd13, S_JR   = 5'd14, S_LUI  = 5'd15
  } state_t;

  state_t     r_state, w_next;

  // R-type funct decode; w_r_ok also qualifies the EX_R transition in ID.
  logic       w_r_ok;
  logic [2:0] w_r_alu;
  always_comb begin
    w_r_ok  = 1'b1;
    w_r_alu = ALU_ADD;
    case (Fun)
      6'b100000: w_r_alu = ALU_ADD;
      6'b100010: w_r_alu = ALU_SUB;
      6'b100100: w_r_alu = ALU_AND;
      6'b100101: w_r_alu = ALU_OR;
      6'b100110: w_r_alu = ALU_XOR;
      6'b100111: w_r_alu = ALU_NOR;
      6'b101010: w_r_alu = ALU_SLT;
      6'b000010: w_r_alu = ALU_SRL;
      default:   w_r_ok  = 1'b0;
    endcase
  end

  logic [2:0] w_i_alu;
  always_comb begin
    w_i_alu = ALU_ADD;
    case (OPcode)
      6'b001100: w_i_alu = ALU_AND;
      6'b001101: w_i_alu = ALU_OR;
      6'b001110: w_i_alu = ALU_XOR;
      6'b001010: w_i_alu = ALU_SLT;
      default:   w_i_alu = ALU_ADD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IF;
    else     r_state <= w_next;
  end

  logic       w_pcwrite, w_iord, w_memread, w_memwrite, w_irwrite, w_regwrite;
  logic       w_srca, w_illegal;
  logic [1:0] w_regdst, w_memtoreg, w_srcb, w_pcsrc;
  logic [2:0] w_alu;

  always_comb begin
    w_next     = r_state;
    w_pcwrite  = 1'b0;
    w_iord     = 1'b0;
    w_memread  = 1'b0;
    w_memwrite = 1'b0;
    w_irwrite  = 1'b0;
    w_regwrite = 1'b0;
    w_srca     = 1'b0;
    w_illegal  = 1'b0;
    w_regdst   = 2'b00;
    w_memtoreg = 2'b00;
    w_srcb     = 2'b00;
    w_pcsrc    = 2'b00;
    w_alu      = 3'b000;
    case (r_state)
      S_IF: begin
        w_memread = 1'b1;
        w_srcb    = 2'b01;
        w_alu     = ALU_ADD;
        w_irwrite = MIO_ready;
        w_pcwrite = MIO_ready;
        if (MIO_ready) w_next = S_ID;
      end
      S_ID: begin
        // Branch target is computed here speculatively into ALUOut.
        w_srcb = 2'b11;
        w_alu  = ALU_ADD;
        case (OPcode)
          6'b000000: begin
            if (w_r_ok)              w_next = S_EX_R;
            else if (Fun == 6'b001000) w_next = S_JR;
            else begin
              w_next    = S_IF;
              w_illegal = 1'b1;
            end
          end
          6'b001000, 6'b001100, 6'b001101,
          6'b001110, 6'b001010: w_next = S_EX_I;
          6'b001111:            w_next = S_LUI;
          6'b100011, 6'b101011: w_next = S_MA;
          6'b000100:            w_next = S_BEQ;
          6'b000101:            w_next = S_BNE;
          6'b000010:            w_next = S_JMP;
          6'b000011:            w_next = S_JAL;
          default: begin
            w_next    = S_IF;
            w_illegal = 1'b1;
          end
        endcase
      end
      S_EX_R: begin
        w_srca = 1'b1;
        w_alu  = w_r_alu;
        w_next = S_WB_R;
      end
      S_WB_R: begin
        w_regdst   = 2'b01;
        w_regwrite = 1'b1;
        w_next     = S_IF;
      end
      S_EX_I: begin
        w_srca = 1'b1;
        w_srcb = 2'b10;
        w_alu  = w_i_alu;
        w_next = S_WB_I;
      end
      S_WB_I: begin
        w_regwrite = 1'b1;
        w_next     = S_IF;
      end
      S_LUI: begin
        w_memtoreg = 2'b10;
        w_regwrite = 1'b1;
        w_next     = S_IF;
      end
      S_MA: begin
        w_srca = 1'b1;
        w_srcb = 2'b10;
        w_alu  = ALU_ADD;
        w_next = (OPcode == 6'b100011) ? S_MRD : S_MWR;
      end
      S_MRD: begin
        w_iord    = 1'b1;
        w_memread = 1'b1;
        if (MIO_ready) w_next = S_WB_LW;
      end
      S_WB_LW: begin
        w_memtoreg = 2'b01;
        w_regwrite = 1'b1;
        w_next     = S_IF;
      end
      S_MWR: begin
        w_iord     = 1'b1;
        w_memwrite = 1'b1;
        if (MIO_ready) w_next = S_IF;
      end
      S_BEQ, S_BNE: begin
        w_srca    = 1'b1;
        w_alu     = ALU_SUB;
        w_pcsrc   = 2'b01;
        w_pcwrite = (r_state == S_BEQ) ? zero : ~zero;
        w_next    = S_IF;
      end
      S_JMP: begin
        w_pcsrc   = 2'b10;
        w_pcwrite = 1'b1;
        w_next    = S_IF;
      end
      S_JAL: begin
        // PC already holds PC+4 here, so the link value is the PC itself.
        w_pcsrc    = 2'b10;
        w_pcwrite  = 1'b1;
        w_regdst   = 2'b10;
        w_memtoreg = 2'b11;
        w_regwrite = 1'b1;
        w_next     = S_IF;
      end
      S_JR: begin
        w_pcsrc   = 2'b11;
        w_pcwrite = 1'b1;
        w_next    = S_IF;
      end
      default: w_next = S_IF;
    endcase
  end

  // rst forces every output low combinationally, so a write in flight drops
  // the moment reset rises rather than at the next clock.
  always_comb begin
    PCWrite     = w_pcwrite  & ~rst;
    IorD        = w_iord     & ~rst;
    MemRead     = w_memread  & ~rst;
    MemWrite    = w_memwrite & ~rst;
    CPU_MIO     = (w_memread | w_memwrite) & ~rst;
    IRWrite     = w_irwrite  & ~rst;
    RegWrite    = w_regwrite & ~rst;
    ALUSrcA     = w_srca     & ~rst;
    illegal     = w_illegal  & ~rst;
    RegDst      = rst ? 2'b00 : w_regdst;
    MemtoReg    = rst ? 2'b00 : w_memtoreg;
    ALUSrcB     = rst ? 2'b00 : w_srcb;
    PCSource    = rst ? 2'b00 : w_pcsrc;
    ALU_Control = rst ? 3'b000 : w_alu;
    state_out   = rst ? '0 : ST_W'(r_state);
  end

endmodule
